// File: rtl/move_seq_pkg.sv
// Shared types and default sizing for the move-command sequencer.
package move_seq_pkg;

    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned DIR_W_DEF    = 2;
    localparam int unsigned SPEED_W_DEF  = 8;
    localparam int unsigned DUR_W_DEF    = 16;
    localparam int unsigned PRESCALE_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DIR_W_DEF-1:0]   dir;
        logic [SPEED_W_DEF-1:0] speed;
        logic [DUR_W_DEF-1:0]   dur;
    } cmd_t;

endpackage

// File: rtl/move_sequencer_if.sv
// CPU write path, playback control and motor/status outputs of the sequencer.
interface move_sequencer_if import move_seq_pkg::*; #(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned DIR_W   = DIR_W_DEF,
    parameter int unsigned SPEED_W = SPEED_W_DEF,
    parameter int unsigned DUR_W   = DUR_W_DEF
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic               wr_en;
    logic [DIR_W-1:0]   wr_dir;
    logic [SPEED_W-1:0] wr_speed;
    logic [DUR_W-1:0]   wr_dur;
    logic               start;
    logic               abort;
    logic [DIR_W-1:0]   motor_dir;
    logic [SPEED_W-1:0] motor_speed;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               overflow;

    modport master (
        output wr_en, wr_dir, wr_speed, wr_dur, start, abort,
        input  motor_dir, motor_speed, busy, done, count, full, empty, overflow
    );

    modport slave (
        input  wr_en, wr_dir, wr_speed, wr_dur, start, abort,
        output motor_dir, motor_speed, busy, done, count, full, empty, overflow
    );

endinterface

// File: rtl/move_fifo.sv
// Command queue: a push on a full queue is taken only when a pop frees a slot the same edge.
module move_fifo import move_seq_pkg::*; #(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    parameter  int unsigned WIDTH = DIR_W_DEF + SPEED_W_DEF + DUR_W_DEF,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clck,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clck) begin
        if (!reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clck) begin
        if (reset && !flush && do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/move_sequencer.sv
// Plays queued move commands back-to-back to the motor drive, each held for max(dur,1)*PRESCALE cycles.
module move_sequencer import move_seq_pkg::*; #(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned DIR_W    = DIR_W_DEF,
    parameter int unsigned SPEED_W  = SPEED_W_DEF,
    parameter int unsigned DUR_W    = DUR_W_DEF,
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input logic             clck,
    input logic             reset,
    move_sequencer_if.slave bus
);
    localparam int unsigned CMD_W = DIR_W + SPEED_W + DUR_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRESCALE - 1);

    state_t             state_q, state_d;
    logic               pop;
    logic               push;
    logic               move_end;
    logic [CMD_W-1:0]   head;
    logic [DIR_W-1:0]   head_dir;
    logic [SPEED_W-1:0] head_speed;
    logic [DUR_W-1:0]   head_dur;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    // abort flushes the queue and swallows any same-cycle write
    assign push = bus.wr_en && !bus.abort;

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clck  (clck),
        .reset (reset),
        .flush (bus.abort),
        .push  (push),
        .pop   (pop),
        .din   ({bus.wr_dir, bus.wr_speed, bus.wr_dur}),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_dir   = head[CMD_W-1 -: DIR_W];
    assign head_speed = head[DUR_W +: SPEED_W];
    assign head_dur   = head[DUR_W-1:0];
    assign move_end   = (pre_q == '0) && (dur_q <= DUR_W'(1));

    always_ff @(posedge clck) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and queue pop
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !fifo_empty) state_d = LOAD;
            LOAD: begin
                pop     = 1'b1;
                state_d = RUN;
            end
            RUN: if (move_end) begin
                if (!fifo_empty) pop = 1'b1;
                else             state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    // Next values of the counters and registered outputs
    always_comb begin
        pre_d   = pre_q;
        dur_d   = dur_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        if (pop) begin
            pre_d   = PRE_LOAD;
            dur_d   = (head_dur == '0) ? DUR_W'(1) : head_dur;
            dir_d   = head_dir;
            speed_d = head_speed;
        end else if (state_q == RUN) begin
            if (pre_q != '0) begin
                pre_d = pre_q - 1'b1;
            end else if (dur_q > DUR_W'(1)) begin
                dur_d = dur_q - 1'b1;
                pre_d = PRE_LOAD;
            end
        end
        if (state_d != RUN) speed_d = '0;
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
        ovf_d  = ovf_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clck) begin
        if (!reset) begin
            pre_q   <= '0;
            dur_q   <= '0;
            dir_q   <= '0;
            speed_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            dur_q   <= dur_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.motor_dir   = dir_q;
    assign bus.motor_speed = speed_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.count       = fifo_count;
    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: queue-level reference model checked every cycle plus literal timelines.
module tb_move_sequencer;
    import move_seq_pkg::*;

    localparam int unsigned P = 2;
    localparam int unsigned D = 8;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    move_sequencer_if #(.DEPTH(D), .DIR_W(2), .SPEED_W(8), .DUR_W(16)) bus ();

    move_sequencer #(
        .DEPTH    (D),
        .DIR_W    (2),
        .SPEED_W  (8),
        .DUR_W    (16),
        .PRESCALE (P)
    ) dut (
        .clck  (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int move_cycles(input logic [15:0] dur);
        return ((dur == 16'd0) ? 1 : int'(dur)) * int'(P);
    endfunction

    // Reference model: phase 0 idle, 1 load, 2 run, 3 done; left = RUN cycles remaining in the move.
    cmd_t       mq[$];
    int         ph = 0;
    int         left = 0;
    logic [1:0] m_dir = '0;
    logic [7:0] m_speed = '0;
    logic       m_ovf = 1'b0;
    bit         model_on = 1'b0;

    always @(posedge clk) begin
        int   sz;
        bit   popped;
        cmd_t c;
        if (!reset) begin
            mq.delete();
            ph = 0; left = 0; m_dir = '0; m_speed = '0; m_ovf = 1'b0;
            model_on = 1'b1;
        end else if (bus.abort) begin
            mq.delete();
            ph = 0;
        end else begin
            sz = mq.size();
            popped = 1'b0;
            case (ph)
                0: if (bus.start && sz > 0) ph = 1;
                1: begin
                    c = mq.pop_front(); popped = 1'b1;
                    m_dir = c.dir; m_speed = c.speed; left = move_cycles(c.dur); ph = 2;
                end
                2: begin
                    left--;
                    if (left == 0) begin
                        if (mq.size() > 0) begin
                            c = mq.pop_front(); popped = 1'b1;
                            m_dir = c.dir; m_speed = c.speed; left = move_cycles(c.dur);
                        end else begin
                            ph = 3;
                        end
                    end
                end
                default: ph = 0;
            endcase
            if (bus.wr_en) begin
                if (sz < int'(D) || popped) mq.push_back('{bus.wr_dir, bus.wr_speed, bus.wr_dur});
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_motor_speed", 32'(bus.motor_speed), (ph == 2) ? 32'(m_speed) : 32'd0);
            chk("model_motor_dir",   32'(bus.motor_dir),   32'(m_dir));
            chk("model_busy",        32'(bus.busy),        32'(ph != 0));
            chk("model_done",        32'(bus.done),        32'(ph == 3));
            chk("model_count",       32'(bus.count),       32'(mq.size()));
            chk("model_full",        32'(bus.full),        32'(mq.size() == int'(D)));
            chk("model_empty",       32'(bus.empty),       32'(mq.size() == 0));
            chk("model_overflow",    32'(bus.overflow),    32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] d, input logic [7:0] s, input logic [15:0] u);
        bus.wr_en = 1'b1; bus.wr_dir = d; bus.wr_speed = s; bus.wr_dur = u;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bit seen;
        reset = 1'b0;
        bus.wr_en = 1'b0; bus.wr_dir = '0; bus.wr_speed = '0; bus.wr_dur = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        tick(); tick();
        chk("rst_speed", 32'(bus.motor_speed), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_overflow", 32'(bus.overflow), 0);
        reset = 1'b1;
        tick();

        // Single move: 3 units x 2 cycles
        wr(2'd1, 8'd50, 16'd3);
        go();
        chk("t1_load_speed", 32'(bus.motor_speed), 0);
        chk("t1_load_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_run_speed", 32'(bus.motor_speed), 50);
            chk("t1_run_dir", 32'(bus.motor_dir), 1);
            chk("t1_run_done", 32'(bus.done), 0);
        end
        tick();
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_done_speed", 32'(bus.motor_speed), 0);
        tick();
        chk("t1_done_clear", 32'(bus.done), 0);
        chk("t1_busy_fall", 32'(bus.busy), 0);

        // Back-to-back moves without a gap
        wr(2'd1, 8'd50, 16'd2);
        wr(2'd2, 8'd80, 16'd1);
        go();
        chk("t2_load_speed", 32'(bus.motor_speed), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_first_speed", 32'(bus.motor_speed), 50);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t2_second_speed", 32'(bus.motor_speed), 80);
            chk("t2_second_dir", 32'(bus.motor_dir), 2);
            chk("t2_second_done", 32'(bus.done), 0);
        end
        tick();
        chk("t2_done", 32'(bus.done), 1);
        tick();
        chk("t2_done_once", 32'(bus.done), 0);
        chk("t2_idle", 32'(bus.busy), 0);

        // Zero duration counts as one unit
        wr(2'd3, 8'd20, 16'd0);
        go();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t6_speed", 32'(bus.motor_speed), 20);
            chk("t6_dir", 32'(bus.motor_dir), 3);
        end
        tick();
        chk("t6_done", 32'(bus.done), 1);
        chk("t6_done_speed", 32'(bus.motor_speed), 0);
        tick();
        chk("t6_idle", 32'(bus.busy), 0);

        // Fill, overflow, then write coinciding with a pop while full
        for (int i = 0; i < int'(D); i++) wr(2'd0, 8'(10 + i), 16'd1);
        chk("t3_count_full", 32'(bus.count), 8);
        chk("t3_full", 32'(bus.full), 1);
        chk("t3_no_ovf", 32'(bus.overflow), 0);
        wr(2'd1, 8'd99, 16'd1);
        chk("t3_drop_count", 32'(bus.count), 8);
        chk("t3_ovf", 32'(bus.overflow), 1);
        go();
        wr(2'd2, 8'd77, 16'd1);
        chk("t3_pop_push_count", 32'(bus.count), 8);
        chk("t3_pop_push_full", 32'(bus.full), 1);
        chk("t3_ovf_sticky", 32'(bus.overflow), 1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        chk("t3_done_seen", 32'(seen), 1);
        tick();
        chk("t3_idle", 32'(bus.busy), 0);
        chk("t3_drained", 32'(bus.count), 0);

        // Abort in the second RUN cycle
        wr(2'd0, 8'd30, 16'd2);
        wr(2'd1, 8'd31, 16'd2);
        wr(2'd2, 8'd32, 16'd2);
        go();
        tick();
        tick();
        chk("t4_pre_speed", 32'(bus.motor_speed), 30);
        chk("t4_pre_count", 32'(bus.count), 2);
        bus.abort = 1'b1; bus.start = 1'b1; bus.wr_en = 1'b1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
        chk("t4_busy", 32'(bus.busy), 0);
        chk("t4_speed", 32'(bus.motor_speed), 0);
        chk("t4_count", 32'(bus.count), 0);
        chk("t4_empty", 32'(bus.empty), 1);
        chk("t4_done", 32'(bus.done), 0);
        tick();
        chk("t4_no_done", 32'(bus.done), 0);
        chk("t4_idle", 32'(bus.busy), 0);

        // Reset mid-RUN with overflow set
        wr(2'd1, 8'd60, 16'd4);
        go();
        tick();
        tick();
        chk("t5_running", 32'(bus.motor_speed), 60);
        chk("t5_ovf_before", 32'(bus.overflow), 1);
        reset = 1'b0;
        tick();
        chk("t5_speed", 32'(bus.motor_speed), 0);
        chk("t5_dir", 32'(bus.motor_dir), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_ovf", 32'(bus.overflow), 0);
        chk("t5_count", 32'(bus.count), 0);
        reset = 1'b1;
        go();
        chk("t5_empty_start", 32'(bus.busy), 0);
        tick();
        chk("t5_stay_idle", 32'(bus.busy), 0);

        // Aborted write on a full queue must not set overflow
        for (int i = 0; i < int'(D); i++) wr(2'd1, 8'(40 + i), 16'd1);
        bus.abort = 1'b1;
        wr(2'd3, 8'd5, 16'd1);
        bus.abort = 1'b0;
        chk("t7_flushed", 32'(bus.count), 0);
        chk("t7_no_ovf", 32'(bus.overflow), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
